multichannel_priority_fifo: RTL and testbench

Strict-priority, N-channel AXI-stream buffer merging several producer streams into one consumer stream. Each channel has its own circular FIFO. An arbiter drains the highest-priority non-empty channel into a registered output stage that follows full AXI-stream handshaking. An optional packet-lock mode keeps a multi-beat packet contiguous on the output. It sits between control/data producers (e.g. register-write, DMA, scope streams) and a shared downstream AXI-stream sink.

---
 rtl/multichannel_priority_fifo_pkg.sv | 11 +
 rtl/multichannel_priority_fifo_channel_buffer.sv | 28 ++
 rtl/multichannel_priority_fifo.sv | 175 +++++++++++++++++
 tb/tb_multichannel_priority_fifo.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/multichannel_priority_fifo_pkg.sv
// Purpose : shared helpers for the multichannel priority FIFO (channel-index width sizing).
// Latency : n/a (compile-time constants only).
// Backpressure: n/a.
package multichannel_priority_fifo_pkg;

    // A single-channel build still needs a 1-bit channel index on the output.
    function automatic int calc_ch_w(input int n_channels);
        return (n_channels > 1) ? $clog2(n_channels) : 1;
    endfunction

endpackage

// File: rtl/multichannel_priority_fifo_channel_buffer.sv
// Purpose : storage array for one channel FIFO; synchronous write port, asynchronous read port.
// Latency : write visible on the read port the cycle after wr_en; read is combinational.
// Backpressure: none here, the parent owns pointers/fill and never writes a full channel.
// Ports   : clock, wr_en/wr_addr/wr_data (write port), rd_addr/rd_data (read port).
module channel_buffer #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 16
) (
    input  logic                     clock,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Payload storage carries no reset; stale words are unreachable once the pointers clear.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/multichannel_priority_fifo.sv
// Purpose : strict-priority merge of N AXI-stream channels (ch0 highest) through per-channel FIFOs
//           into one registered output stage, optionally keeping multi-beat packets contiguous.
// Latency : 2 cycles input valid -> output valid; 1 beat/cycle sustained with data_out_ready high.
// Backpressure: data_in_ready[c] drops when channel c holds FIFO_DEPTH beats; output held while stalled.
// Ports   : clock, reset (sync, active-low); data_in/_valid/_tlast/_ready (per-channel slices);
//           data_out/_valid/_tlast/_channel/_ready (merged stream plus source channel).
module multichannel_priority_fifo
    import multichannel_priority_fifo_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int N_CHANNELS  = 4,
    parameter int FIFO_DEPTH  = 16,
    parameter int PACKET_LOCK = 1
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [N_CHANNELS*DATA_WIDTH-1:0] data_in,
    input  logic [N_CHANNELS-1:0]            data_in_valid,
    input  logic [N_CHANNELS-1:0]            data_in_tlast,
    output logic [N_CHANNELS-1:0]            data_in_ready,
    output logic [DATA_WIDTH-1:0]            data_out,
    output logic                             data_out_valid,
    output logic                             data_out_tlast,
    output logic [calc_ch_w(N_CHANNELS)-1:0] data_out_channel,
    input  logic                             data_out_ready
);

    localparam int ADDR_W  = $clog2(FIFO_DEPTH);
    localparam int CH_W    = calc_ch_w(N_CHANNELS);
    localparam int ENTRY_W = DATA_WIDTH + 1;
    localparam logic [ADDR_W:0] FULL_LEVEL = (ADDR_W+1)'(FIFO_DEPTH);

    logic [ADDR_W-1:0]     wr_ptr_q [N_CHANNELS];
    logic [ADDR_W-1:0]     wr_ptr_d [N_CHANNELS];
    logic [ADDR_W-1:0]     rd_ptr_q [N_CHANNELS];
    logic [ADDR_W-1:0]     rd_ptr_d [N_CHANNELS];
    logic [ADDR_W:0]       fill_q   [N_CHANNELS];
    logic [ADDR_W:0]       fill_d   [N_CHANNELS];
    logic [ENTRY_W-1:0]    rd_word  [N_CHANNELS];

    logic [N_CHANNELS-1:0] push;
    logic [N_CHANNELS-1:0] nonempty;
    logic [N_CHANNELS-1:0] eligible;
    logic                  found;
    logic [CH_W-1:0]       winner;
    logic [ENTRY_W-1:0]    win_word;
    logic                  out_free;
    logic                  pop_any;

    logic                  lock_active_q, lock_active_d;
    logic [CH_W-1:0]       lock_ch_q, lock_ch_d;

    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  data_out_vld_q, data_out_vld_d;
    logic                  data_out_last_q, data_out_last_d;
    logic [CH_W-1:0]       data_out_ch_q, data_out_ch_d;

    // Per-channel storage plus handshake decode.
    for (genvar c = 0; c < N_CHANNELS; c++) begin : g_ch
        // Ready comes from the registered fill only, so a pop in the same cycle cannot
        // open a full channel and there is no combinational path from data_out_ready.
        assign data_in_ready[c] = (fill_q[c] != FULL_LEVEL);
        assign push[c]          = data_in_valid[c] && data_in_ready[c];
        assign nonempty[c]      = (fill_q[c] != '0);

        channel_buffer #(
            .WIDTH (ENTRY_W),
            .DEPTH (FIFO_DEPTH)
        ) u_buf (
            .clock   (clock),
            .wr_en   (push[c]),
            .wr_addr (wr_ptr_q[c]),
            .wr_data ({data_in_tlast[c], data_in[c*DATA_WIDTH +: DATA_WIDTH]}),
            .rd_addr (rd_ptr_q[c]),
            .rd_data (rd_word[c])
        );
    end

    // Arbiter: mask down to the locked channel while a packet is open, then take the lowest index.
    always_comb begin
        out_free = !data_out_vld_q || data_out_ready;
        eligible = '0;
        for (int c = 0; c < N_CHANNELS; c++) begin
            if ((PACKET_LOCK != 0) && lock_active_q) begin
                eligible[c] = nonempty[c] && (CH_W'(c) == lock_ch_q);
            end else begin
                eligible[c] = nonempty[c];
            end
        end

        found    = 1'b0;
        winner   = '0;
        win_word = '0;
        // Descending scan so the lowest eligible index is the last (winning) assignment.
        for (int c = N_CHANNELS - 1; c >= 0; c--) begin
            if (eligible[c]) begin
                found    = 1'b1;
                winner   = CH_W'(c);
                win_word = rd_word[c];
            end
        end
        pop_any = out_free && found;
    end

    // Pointer / fill / output-stage / lock next state.
    always_comb begin
        lock_active_d   = lock_active_q;
        lock_ch_d       = lock_ch_q;
        data_out_d      = data_out_q;
        data_out_vld_d  = data_out_vld_q;
        data_out_last_d = data_out_last_q;
        data_out_ch_d   = data_out_ch_q;

        for (int c = 0; c < N_CHANNELS; c++) begin
            logic pop_c;
            pop_c       = pop_any && (winner == CH_W'(c));
            wr_ptr_d[c] = wr_ptr_q[c] + ADDR_W'(push[c]);
            rd_ptr_d[c] = rd_ptr_q[c] + ADDR_W'(pop_c);
            case ({push[c], pop_c})
                2'b10:   fill_d[c] = fill_q[c] + 1'b1;
                2'b01:   fill_d[c] = fill_q[c] - 1'b1;
                default: fill_d[c] = fill_q[c];
            endcase
        end

        if (out_free) begin
            if (found) begin
                data_out_d      = win_word[DATA_WIDTH-1:0];
                data_out_last_d = win_word[DATA_WIDTH];
                data_out_ch_d   = winner;
                data_out_vld_d  = 1'b1;
                if (PACKET_LOCK != 0) begin
                    lock_active_d = !win_word[DATA_WIDTH];
                    lock_ch_d     = winner;
                end
            end else begin
                data_out_vld_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int c = 0; c < N_CHANNELS; c++) begin
                wr_ptr_q[c] <= '0;
                rd_ptr_q[c] <= '0;
                fill_q[c]   <= '0;
            end
            lock_active_q   <= 1'b0;
            lock_ch_q       <= '0;
            data_out_q      <= '0;
            data_out_vld_q  <= 1'b0;
            data_out_last_q <= 1'b0;
            data_out_ch_q   <= '0;
        end else begin
            for (int c = 0; c < N_CHANNELS; c++) begin
                wr_ptr_q[c] <= wr_ptr_d[c];
                rd_ptr_q[c] <= rd_ptr_d[c];
                fill_q[c]   <= fill_d[c];
            end
            lock_active_q   <= lock_active_d;
            lock_ch_q       <= lock_ch_d;
            data_out_q      <= data_out_d;
            data_out_vld_q  <= data_out_vld_d;
            data_out_last_q <= data_out_last_d;
            data_out_ch_q   <= data_out_ch_d;
        end
    end

    assign data_out         = data_out_q;
    assign data_out_valid   = data_out_vld_q;
    assign data_out_tlast   = data_out_last_q;
    assign data_out_channel = data_out_ch_q;

endmodule

// File: tb/tb_multichannel_priority_fifo.sv
// Purpose : directed self-checking bench; dut runs with packet lock, dut_nl without, on shared stimulus.
// Latency : outputs sampled 1 time unit after each rising edge.
// Backpressure: data_out_ready driven by the bench (held low while preloading, toggled in the stall test).
module tb_multichannel_priority_fifo;

    localparam int DW   = 32;
    localparam int NCH  = 4;
    localparam int CHW  = 2;

    typedef struct packed {
        logic [DW-1:0]  d;
        logic [CHW-1:0] ch;
        logic           last;
    } beat_t;

    logic             clk = 1'b0;
    logic             reset;
    logic [NCH*DW-1:0] data_in;
    logic [NCH-1:0]   data_in_valid;
    logic [NCH-1:0]   data_in_tlast;
    logic             data_out_ready;

    logic [NCH-1:0]   rdy_a, rdy_b;
    logic [DW-1:0]    dout_a, dout_b;
    logic             vld_a, vld_b, last_a, last_b;
    logic [CHW-1:0]   ch_a, ch_b;

    int    checks   = 0;
    int    failures = 0;
    beat_t qa[$];
    beat_t qb[$];

    always #5 clk = ~clk;

    multichannel_priority_fifo #(
        .DATA_WIDTH(DW), .N_CHANNELS(NCH), .FIFO_DEPTH(16), .PACKET_LOCK(1)
    ) dut (
        .clock(clk), .reset(reset),
        .data_in(data_in), .data_in_valid(data_in_valid), .data_in_tlast(data_in_tlast),
        .data_in_ready(rdy_a),
        .data_out(dout_a), .data_out_valid(vld_a), .data_out_tlast(last_a),
        .data_out_channel(ch_a), .data_out_ready(data_out_ready)
    );

    multichannel_priority_fifo #(
        .DATA_WIDTH(DW), .N_CHANNELS(NCH), .FIFO_DEPTH(16), .PACKET_LOCK(0)
    ) dut_nl (
        .clock(clk), .reset(reset),
        .data_in(data_in), .data_in_valid(data_in_valid), .data_in_tlast(data_in_tlast),
        .data_in_ready(rdy_b),
        .data_out(dout_b), .data_out_valid(vld_b), .data_out_tlast(last_b),
        .data_out_channel(ch_b), .data_out_ready(data_out_ready)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic beat_t mk(input logic [DW-1:0] d, input logic [CHW-1:0] c, input logic l);
        return {d, c, l};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_all();
        reset          = 1'b0;
        data_in_valid  = '0;
        data_in_tlast  = '0;
        data_out_ready = 1'b0;
        tick();
        reset = 1'b1;
        qa.delete();
        qb.delete();
    endtask

    task automatic push_beat(input int ch, input logic [DW-1:0] d, input logic l);
        data_in_valid          = '0;
        data_in_valid[ch]      = 1'b1;
        data_in_tlast[ch]      = l;
        data_in[ch*DW +: DW]   = d;
        tick();
        data_in_valid[ch]      = 1'b0;
    endtask

    // Ready held high; every sample with valid set is a distinct beat consumed at the next edge.
    task automatic collect(input int cycles);
        data_out_ready = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            if (vld_a) qa.push_back(mk(dout_a, ch_a, last_a));
            if (vld_b) qb.push_back(mk(dout_b, ch_b, last_b));
            tick();
        end
        data_out_ready = 1'b0;
    endtask

    // Missing beats read as all ones, which no expected beat uses.
    task automatic expect_beat(input string tag, input int side, input int idx, input beat_t exp);
        beat_t got;
        if (side == 0) got = (idx < qa.size()) ? qa[idx] : '1;
        else           got = (idx < qb.size()) ? qb[idx] : '1;
        check($sformatf("%s[%0d]", tag, idx), 64'(got), 64'(exp));
    endtask

    initial begin
        int             sent;
        int             got;
        logic           stall;
        logic           in_ok;
        logic [DW-1:0]  sd;
        logic [CHW-1:0] sc;
        logic           sl;

        data_in = '0;

        // ---- reset state ----
        reset_all();
        tick();
        check("rst_out", {dout_a, vld_a, last_a, ch_a}, 64'h0);
        check("rst_rdy", rdy_a, 4'hF);

        // ---- fill ch2; the output stage absorbs the first beat, so 17 beats fill it ----
        reset_all();
        for (int i = 0; i < 17; i++) begin
            push_beat(2, DW'(32'h100 + i), 1'b1);
            if (i == 15) check("full_rdy_at16", rdy_a[2], 1'b1);
        end
        check("full_rdy_at17", rdy_a[2], 1'b0);
        check("full_hold", {vld_a, ch_a, dout_a}, {1'b1, 2'd2, 32'h100});
        collect(25);
        check("full_count", qa.size(), 17);
        for (int i = 0; i < 17; i++) expect_beat("full_beat", 0, i, mk(DW'(32'h100 + i), 2'd2, 1'b1));
        check("full_rdy_after", rdy_a[2], 1'b1);
        check("full_idle", vld_a, 1'b0);

        // ---- priority: ch0 and ch3 loaded together, ch0 first ----
        reset_all();
        data_in_valid          = 4'b1001;
        data_in_tlast          = 4'b1111;
        data_in[0 +: DW]       = 32'h01;
        data_in[3*DW +: DW]    = 32'hA0;
        tick();
        data_in_valid = '0;
        for (int i = 1; i < 4; i++) push_beat(3, DW'(32'hA0 + i), 1'b1);
        collect(12);
        check("prio_count", qa.size(), 5);
        expect_beat("prio_beat", 0, 0, mk(32'h01, 2'd0, 1'b1));
        for (int i = 0; i < 4; i++) expect_beat("prio_beat", 0, i + 1, mk(DW'(32'hA0 + i), 2'd3, 1'b1));

        // ---- packet lock vs. re-arbitration per beat ----
        reset_all();
        push_beat(1, 32'h10, 1'b0);
        push_beat(1, 32'h11, 1'b0);
        push_beat(1, 32'h12, 1'b1);
        push_beat(0, 32'h55, 1'b1);
        collect(10);
        check("lock_count", qa.size(), 4);
        expect_beat("lock_beat", 0, 0, mk(32'h10, 2'd1, 1'b0));
        expect_beat("lock_beat", 0, 1, mk(32'h11, 2'd1, 1'b0));
        expect_beat("lock_beat", 0, 2, mk(32'h12, 2'd1, 1'b1));
        expect_beat("lock_beat", 0, 3, mk(32'h55, 2'd0, 1'b1));
        check("nolock_count", qb.size(), 4);
        expect_beat("nolock_beat", 1, 0, mk(32'h10, 2'd1, 1'b0));
        expect_beat("nolock_beat", 1, 1, mk(32'h55, 2'd0, 1'b1));
        expect_beat("nolock_beat", 1, 2, mk(32'h11, 2'd1, 1'b0));
        expect_beat("nolock_beat", 1, 3, mk(32'h12, 2'd1, 1'b1));

        // ---- backpressure: ready toggles every cycle over a 20-beat stream ----
        reset_all();
        sent  = 0;
        got   = 0;
        stall = 1'b0;
        sd    = '0;
        sc    = '0;
        sl    = 1'b0;
        for (int cyc = 0; cyc < 400 && got < 20; cyc++) begin
            if (stall) check("bp_hold", {vld_a, sl ^ last_a, sc ^ ch_a, dout_a}, {1'b1, 1'b0, 2'b00, sd});
            data_out_ready = (cyc % 2 == 1);
            if (vld_a && data_out_ready) begin
                check($sformatf("bp_order[%0d]", got), {ch_a, last_a, dout_a}, {2'd0, 1'b1, DW'(32'h200 + got)});
                got++;
            end
            stall = vld_a && !data_out_ready;
            sd    = dout_a;
            sc    = ch_a;
            sl    = last_a;
            if (sent < 20) begin
                data_in_valid[0]  = 1'b1;
                data_in_tlast[0]  = 1'b1;
                data_in[0 +: DW]  = DW'(32'h200 + sent);
            end else begin
                data_in_valid[0]  = 1'b0;
            end
            in_ok = data_in_valid[0] && rdy_a[0];
            tick();
            if (in_ok) sent++;
        end
        data_in_valid  = '0;
        data_out_ready = 1'b0;
        check("bp_count", got, 20);
        tick();
        check("bp_drained", vld_a, 1'b0);

        // ---- reset mid-packet, then a fresh beat on another channel ----
        reset_all();
        for (int i = 0; i < 5; i++) push_beat(1, DW'(32'h30 + i), 1'b0);
        check("mid_pkt_out", {vld_a, ch_a, dout_a}, {1'b1, 2'd1, 32'h30});
        reset = 1'b0;
        tick();
        check("mid_rst_out", {dout_a, vld_a, last_a, ch_a}, 64'h0);
        check("mid_rst_rdy", rdy_a, 4'hF);
        reset = 1'b1;
        push_beat(2, 32'h77, 1'b1);
        check("post_rst_lat1", vld_a, 1'b0);
        tick();
        check("post_rst_beat", {vld_a, last_a, ch_a, dout_a}, {1'b1, 1'b1, 2'd2, 32'h77});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
